temp_bcd_fmt: RTL and testbench

Source-side formatter feeding the six-digit seven-segment display driver. Accepts a 16-bit signed fixed-point temperature sample (DS18B20 format, 4 fractional bits, LSB = 0.0625 °C). Converts it serially with double-dabble to six BCD nibbles: sign/hundreds, tens, units, and three fractional digits. Drives the display driver's digit bus and per-digit valid mask.

---
 rtl/temp_bcd_fmt.sv | 142 ++++++++++++++
 tb/tb_temp_bcd_fmt.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/temp_bcd_fmt.sv
// Signed 12.4 fixed-point temperature to six BCD digits (serial double-dabble) for the 7-seg driver.
// Latency: 27 clocks from temp_vld to dout/dout_vld; busy high meanwhile, temp_vld dropped while busy.
// Optional macro TEMP_BCD_CHANGED_ONLY_EN: dout_vld flags only the digits that changed.
module temp_bcd_fmt #(
    parameter logic [3:0] NEG_CODE  = 4'hF,
    parameter int         DIGIT_NUM = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [15:0]            temp_data,
    input  logic                   temp_vld,
    output logic [4*DIGIT_NUM-1:0] dout,
    output logic [DIGIT_NUM-1:0]   dout_vld,
    output logic                   busy
);

    typedef enum logic [1:0] {IDLE, CONV_INT, CONV_FRAC, DONE} state_t;

    state_t state, state_nxt;

    logic                   sign;
    logic [13:0]            bin;
    logic [15:0]            bcd;
    logic [15:0]            int_bcd;
    logic [3:0]             frac_nib;
    logic [3:0]             cnt;
    logic [15:0]            mag;
    logic [13:0]            frac_scaled;
    logic [15:0]            bcd_adj;
    logic [15:0]            bcd_step;
    logic [4*DIGIT_NUM-1:0] dout_new;
    logic [DIGIT_NUM-1:0]   vld_mask;

    // 16'h8000 negates to itself, which is the correct unsigned magnitude
    assign mag         = temp_data[15] ? (~temp_data + 16'd1) : temp_data;
    assign frac_scaled = 14'(frac_nib) * 14'd625;

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
        bcd_step = {bcd_adj[14:0], bin[13]};
    end

    // Integer digits live in int_bcd; bcd holds the fractional result once in DONE
    always_comb begin
        dout_new = '0;
        if (sign) begin
            if (int_bcd[15:8] != 8'h00)
                dout_new = {NEG_CODE, 20'h99999};
            else
                dout_new = {NEG_CODE, int_bcd[7:0], bcd[15:4]};
        end else begin
            if (int_bcd[15:12] != 4'h0)
                dout_new = 24'h999999;
            else
                dout_new = {int_bcd[11:0], bcd[15:4]};
        end
    end

`ifdef TEMP_BCD_CHANGED_ONLY_EN
    always_comb begin
        vld_mask = '0;
        for (int i = 0; i < DIGIT_NUM; i++)
            vld_mask[i] = (dout_new[4*i +: 4] != dout[4*i +: 4]);
    end
`else
    assign vld_mask = '1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (temp_vld)      state_nxt = CONV_INT;
            CONV_INT:  if (cnt == 4'd11)  state_nxt = CONV_FRAC;
            CONV_FRAC: if (cnt == 4'd13)  state_nxt = DONE;
            DONE:                         state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign     <= 1'b0;
            bin      <= '0;
            bcd      <= '0;
            int_bcd  <= '0;
            frac_nib <= '0;
            cnt      <= '0;
            dout     <= '0;
            dout_vld <= '0;
            busy     <= 1'b0;
        end else begin
            dout_vld <= '0;
            case (state)
                IDLE: begin
                    if (temp_vld) begin
                        sign     <= temp_data[15];
                        bin      <= {mag[15:4], 2'b00};
                        frac_nib <= mag[3:0];
                        bcd      <= '0;
                        cnt      <= '0;
                        busy     <= 1'b1;
                    end
                end
                CONV_INT: begin
                    if (cnt == 4'd11) begin
                        int_bcd <= bcd_step;
                        bcd     <= '0;
                        bin     <= frac_scaled;
                        cnt     <= '0;
                    end else begin
                        bcd <= bcd_step;
                        bin <= {bin[12:0], 1'b0};
                        cnt <= cnt + 4'd1;
                    end
                end
                CONV_FRAC: begin
                    bcd <= bcd_step;
                    bin <= {bin[12:0], 1'b0};
                    cnt <= cnt + 4'd1;
                end
                DONE: begin
                    dout     <= dout_new;
                    dout_vld <= vld_mask;
                    busy     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_temp_bcd_fmt.sv
// Directed bench for temp_bcd_fmt (default build): latency, digit assembly, saturation, drop/accept, reset abort.
module tb_temp_bcd_fmt;

    logic        clk;
    logic        rst_n;
    logic [15:0] temp_data;
    logic        temp_vld;
    logic [23:0] dout;
    logic [5:0]  dout_vld;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;

    temp_bcd_fmt dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .temp_data (temp_data),
        .temp_vld  (temp_vld),
        .dout      (dout),
        .dout_vld  (dout_vld),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Present a one-cycle strobe; returns #1 after the sampling edge
    task automatic send(input logic [15:0] d);
        temp_data = d;
        temp_vld  = 1'b1;
        @(posedge clk);
        #1;
        temp_vld  = 1'b0;
    endtask

    // Counts edges until dout_vld rises (bounded); also counts busy-high samples
    task automatic wait_vld(input int limit, output int edges, output int busy_cnt);
        edges    = 0;
        busy_cnt = busy ? 1 : 0;
        while (edges < limit) begin
            @(posedge clk);
            #1;
            edges++;
            if (dout_vld != 6'h00) break;
            if (busy) busy_cnt++;
        end
    endtask

    task automatic convert(input string tag, input logic [15:0] d, input logic [23:0] exp);
        int e, b;
        send(d);
        wait_vld(40, e, b);
        chk({tag, "_lat"}, e, 27);
        chk({tag, "_dout"}, dout, exp);
        chk({tag, "_vld"}, dout_vld, 6'h3F);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int e, b, extra;
        rst_n     = 1'b0;
        temp_data = '0;
        temp_vld  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout", dout, 24'h0);
        chk("rst_vld", dout_vld, 6'h0);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // +25.0625 with busy window and single-cycle pulse
        send(16'h0191);
        chk("pos25_busy_start", busy, 1'b1);
        wait_vld(40, e, b);
        chk("pos25_lat", e, 27);
        chk("pos25_busy_cycles", b, 27);
        chk("pos25_busy_end", busy, 1'b0);
        chk("pos25_dout", dout, 24'h025062);
        chk("pos25_vld", dout_vld, 6'h3F);
        @(posedge clk);
        #1;
        chk("pos25_pulse_end", dout_vld, 6'h00);
        chk("pos25_hold", dout, 24'h025062);

        convert("neg10", 16'hFF5E, 24'hF10125);
        convert("neg55", 16'hFC90, 24'hF55000);
        convert("pos125", 16'h07DF, 24'h125937);
        convert("sat_pos", 16'h7FF0, 24'h999999);
        convert("sat_neg", 16'hF9C0, 24'hF99999);
        convert("min_neg", 16'h8000, 24'hF99999);
        convert("zero", 16'h0000, 24'h000000);
        convert("neg_frac", 16'hFFF8, 24'hF00500);

        // Second strobe 5 cycles into a conversion is dropped
        send(16'h0191);
        repeat (4) @(posedge clk);
        #1;
        send(16'h07DF);
        wait_vld(40, e, b);
        chk("drop_lat", e + 5, 27);
        chk("drop_dout", dout, 24'h025062);
        // Strobe coincident with the pulse is accepted
        send(16'hFF5E);
        wait_vld(40, e, b);
        chk("coinc_lat", e, 27);
        chk("coinc_dout", dout, 24'hF10125);
        extra = 0;
        for (int i = 0; i < 35; i++) begin
            @(posedge clk);
            #1;
            if (dout_vld != 6'h00) extra++;
        end
        chk("drop_no_extra_pulse", extra, 0);

        // Reset 10 cycles into a conversion aborts it
        send(16'h07DF);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_dout", dout, 24'h0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_vld", dout_vld, 6'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        extra = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (dout_vld != 6'h00 || busy) extra++;
        end
        chk("abort_no_pulse", extra, 0);
        convert("post_abort", 16'hFC90, 24'hF55000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
